mem_arbiter: RTL and testbench
==============================

MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameters: none; all widths fixed.
REQ-002 clk  input  1  single system clock; all state updates on rising edge.
REQ-003 reset  input  1  synchronous, active-high reset.
REQ-004 instr_read  input  1  fetch request; held high until instr_valid.
REQ-005 instr_address  input  32  fetch byte address; held stable while instr_read high.
REQ-006 instr_readdata  output  32  fetched word; valid while instr_valid high.
REQ-007 instr_valid  output  1  registered one-cycle fetch completion pulse.
REQ-008 data_read  input  1  data load request; held until data_valid.
REQ-009 data_write  input  1  data store request; held until data_valid.
REQ-010 data_address  input  32  data byte address.
REQ-011 data_writedata  input  32  store data.
REQ-012 data_byteenable  input  4  store/load lane enables.
REQ-013 data_readdata  output  32  load result; valid while data_valid high.
REQ-014 data_valid  output  1  registered one-cycle data completion pulse.
REQ-015 address  output  32  bus address, always {addr[31:2],2'b00}.
REQ-016 read, write  output  1 each  bus strobes, registered, never both high.
REQ-017 writedata  output  32  bus store data.
REQ-018 byteenable  output  4  bus lanes; 4'b1111 for fetches.
REQ-019 waitrequest  input  1  bus stall; transfer completes in a cycle with strobe high and waitrequest low.
REQ-020 readdata  input  32  bus read data, sampled in the completing cycle.
REQ-021 memory_hazard  output  1  combinational PC stall = instr_read & ~instr_valid.

Function
REQ-022 States IDLE, DATA, FETCH; from IDLE, DATA when a data request is pending, else FETCH when instr_read is pending, else stay IDLE.
REQ-023 Starvation rule: if the previous grant was DATA and instr_read is pending, FETCH is granted before any further DATA grant.
REQ-024 On entering DATA/FETCH, address, strobe, writedata and byteenable are registered and held constant until completion.
REQ-025 Latency: request seen in IDLE in cycle N, strobe high in N+1; with waitrequest low in N+1, valid pulses in N+2; each waitrequest-high cycle adds one cycle.
REQ-026 On completion: strobe drops, readdata is latched into the port's readdata register, the port's valid pulses for one cycle, and the state returns to IDLE.
REQ-027 In the cycle a port's valid is high, that port's request is ignored, preventing re-issue.
REQ-028 If data_read and data_write are both high, the write is performed and data_valid completes both.
REQ-029 instr_readdata and data_readdata hold their last values until overwritten.

Reset
REQ-030 During reset: state IDLE; read, write, instr_valid and data_valid at 0; address, writedata and readdata registers at 0; byteenable 4'b0000; last-grant flag cleared.
REQ-031 Reset mid-transfer abandons it: strobes drop on the same edge and no valid pulse is issued.

Configuration
REQ-032 With MEM_ARBITER_FETCH_BUFFER_EN defined: a one-entry buffer (tag, word, valid) holds the last fetch; a fetch hitting the tag completes from IDLE with instr_valid in N+1 and no bus cycle; a completed data_write to the tagged word clears the buffer; reset clears it.
REQ-033 Without MEM_ARBITER_FETCH_BUFFER_EN: every fetch uses the bus, and no buffer registers exist.

Verification
REQ-034 Fetch 0xBFC00000, waitrequest low, readdata 0x24020005 -> read=1 in N+1, instr_valid=1 and instr_readdata=0x24020005 in N+2, memory_hazard=1 in N..N+1.
REQ-035 data_write 0x00001003 (byteenable 4'b1000) and instr_read together -> write=1, address 0x00001000 first; the fetch follows; memory_hazard is held until instr_valid.
REQ-036 Load 0x00000010 with waitrequest high for 3 cycles -> address and read held stable, data_valid exactly 4 cycles after read first rises.
REQ-037 Back-to-back data requests with a fetch pending -> the grant order is DATA, FETCH, DATA.
REQ-038 Reset asserted while read=1 with waitrequest high -> next cycle read=0, no valid pulse, state IDLE.
REQ-039 Buffer build only: fetch 0xBFC00004 twice -> the second instr_valid comes 1 cycle after the request with no read strobe; after a write to 0xBFC00004, the next fetch uses the bus.

Source files
------------

// File: rtl/mem_arbiter.sv
// ============================================================================
// Module      : mem_arbiter
// Description : Two-port (instruction fetch / data load-store) arbiter onto a
//               single waitrequest-style memory bus. Optional one-entry fetch
//               buffer enabled by defining MEM_ARBITER_FETCH_BUFFER_EN.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module mem_arbiter (
    input  logic        clk,
    input  logic        reset,

    input  logic        instr_read,
    input  logic [31:0] instr_address,
    output logic [31:0] instr_readdata,
    output logic        instr_valid,

    input  logic        data_read,
    input  logic        data_write,
    input  logic [31:0] data_address,
    input  logic [31:0] data_writedata,
    input  logic [3:0]  data_byteenable,
    output logic [31:0] data_readdata,
    output logic        data_valid,

    output logic [31:0] address,
    output logic        read,
    output logic        write,
    output logic [31:0] writedata,
    output logic [3:0]  byteenable,
    input  logic        waitrequest,
    input  logic [31:0] readdata,

    output logic        memory_hazard
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        DATA  = 2'd1,
        FETCH = 2'd2
    } state_t;

    state_t      r_state;
    state_t      w_next_state;

    logic [31:0] r_address;
    logic        r_read;
    logic        r_write;
    logic [31:0] r_writedata;
    logic [3:0]  r_byteenable;
    logic [31:0] r_instr_readdata;
    logic        r_instr_valid;
    logic [31:0] r_data_readdata;
    logic        r_data_valid;
    logic        r_last_data;

    logic        w_instr_req;
    logic        w_data_req;
    logic        w_done;
    logic        w_grant_data;
    logic        w_grant_fetch;
    logic        w_fetch_hit;
    logic        w_buf_hit;
    logic [31:0] w_buf_word;
    logic        w_unused_addr_bits;

    // A port whose valid is high this cycle is ignored so its held request is not re-issued.
    assign w_instr_req = instr_read & ~r_instr_valid;
    assign w_data_req  = (data_read | data_write) & ~r_data_valid;
    assign w_done      = (r_read | r_write) & ~waitrequest;

    assign w_unused_addr_bits = &{1'b0, instr_address[1:0], data_address[1:0]};

`ifdef MEM_ARBITER_FETCH_BUFFER_EN
    logic        r_buf_valid;
    logic [29:0] r_buf_tag;
    logic [31:0] r_buf_word;

    assign w_buf_hit  = r_buf_valid & (r_buf_tag == instr_address[31:2]);
    assign w_buf_word = r_buf_word;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_buf_valid <= 1'b0;
            r_buf_tag   <= 30'd0;
            r_buf_word  <= 32'd0;
        end else if (w_done && r_state == FETCH) begin
            r_buf_valid <= 1'b1;
            r_buf_tag   <= r_address[31:2];
            r_buf_word  <= readdata;
        end else if (w_done && r_write && r_buf_valid && r_buf_tag == r_address[31:2]) begin
            r_buf_valid <= 1'b0;
        end
    end
`else
    assign w_buf_hit  = 1'b0;
    assign w_buf_word = 32'd0;
`endif

    always_comb begin
        w_next_state  = r_state;
        w_grant_data  = 1'b0;
        w_grant_fetch = 1'b0;
        w_fetch_hit   = 1'b0;
        case (r_state)
            IDLE: begin
                // After a data grant, a waiting fetch goes first.
                if (w_data_req && !(w_instr_req && r_last_data)) begin
                    w_grant_data = 1'b1;
                    w_next_state = DATA;
                end else if (w_instr_req) begin
                    if (w_buf_hit) begin
                        w_fetch_hit = 1'b1;
                    end else begin
                        w_grant_fetch = 1'b1;
                        w_next_state  = FETCH;
                    end
                end
            end
            DATA, FETCH: begin
                if (!waitrequest) begin
                    w_next_state = IDLE;
                end
            end
            default: begin
                w_next_state = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state          <= IDLE;
            r_address        <= 32'd0;
            r_read           <= 1'b0;
            r_write          <= 1'b0;
            r_writedata      <= 32'd0;
            r_byteenable     <= 4'b0000;
            r_instr_readdata <= 32'd0;
            r_instr_valid    <= 1'b0;
            r_data_readdata  <= 32'd0;
            r_data_valid     <= 1'b0;
            r_last_data      <= 1'b0;
        end else begin
            r_state       <= w_next_state;
            r_instr_valid <= 1'b0;
            r_data_valid  <= 1'b0;

            if (w_grant_data) begin
                // A simultaneous read and write performs the write.
                r_address    <= {data_address[31:2], 2'b00};
                r_write      <= data_write;
                r_read       <= ~data_write;
                r_writedata  <= data_writedata;
                r_byteenable <= data_byteenable;
                r_last_data  <= 1'b1;
            end else if (w_grant_fetch) begin
                r_address    <= {instr_address[31:2], 2'b00};
                r_read       <= 1'b1;
                r_write      <= 1'b0;
                r_byteenable <= 4'b1111;
                r_last_data  <= 1'b0;
            end else if (w_fetch_hit) begin
                r_instr_readdata <= w_buf_word;
                r_instr_valid    <= 1'b1;
                r_last_data      <= 1'b0;
            end

            if (w_done) begin
                r_read  <= 1'b0;
                r_write <= 1'b0;
                if (r_state == FETCH) begin
                    r_instr_readdata <= readdata;
                    r_instr_valid    <= 1'b1;
                end else begin
                    r_data_readdata <= readdata;
                    r_data_valid    <= 1'b1;
                end
            end
        end
    end

    assign address        = r_address;
    assign read           = r_read;
    assign write          = r_write;
    assign writedata      = r_writedata;
    assign byteenable     = r_byteenable;
    assign instr_readdata = r_instr_readdata;
    assign instr_valid    = r_instr_valid;
    assign data_readdata  = r_data_readdata;
    assign data_valid     = r_data_valid;
    assign memory_hazard  = instr_read & ~r_instr_valid;

endmodule

`default_nettype wire

// File: tb/tb_mem_arbiter.sv
// ============================================================================
// Module      : tb_mem_arbiter
// Description : Randomized bench for mem_arbiter; a memory-backed bus slave and
//               a transaction-level arbitration model predict every cycle.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_mem_arbiter;

    logic        clk = 1'b0;
    logic        reset;
    logic        instr_read;
    logic [31:0] instr_address;
    logic [31:0] instr_readdata;
    logic        instr_valid;
    logic        data_read;
    logic        data_write;
    logic [31:0] data_address;
    logic [31:0] data_writedata;
    logic [3:0]  data_byteenable;
    logic [31:0] data_readdata;
    logic        data_valid;
    logic [31:0] address;
    logic        read;
    logic        write;
    logic [31:0] writedata;
    logic [3:0]  byteenable;
    logic        waitrequest;
    logic [31:0] readdata;
    logic        memory_hazard;

    mem_arbiter u_dut (
        .clk             (clk),
        .reset           (reset),
        .instr_read      (instr_read),
        .instr_address   (instr_address),
        .instr_readdata  (instr_readdata),
        .instr_valid     (instr_valid),
        .data_read       (data_read),
        .data_write      (data_write),
        .data_address    (data_address),
        .data_writedata  (data_writedata),
        .data_byteenable (data_byteenable),
        .data_readdata   (data_readdata),
        .data_valid      (data_valid),
        .address         (address),
        .read            (read),
        .write           (write),
        .writedata       (writedata),
        .byteenable      (byteenable),
        .waitrequest     (waitrequest),
        .readdata        (readdata),
        .memory_hazard   (memory_hazard)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    // expected DUT outputs for the next observed cycle
    logic        e_read, e_write, e_ivalid, e_dvalid, e_regs_check;
    logic [31:0] e_addr, e_wd, e_ird, e_drd;
    logic [3:0]  e_be;

    // reference model state
    logic [31:0] mem [logic [29:0]];
    bit          last_data;
    bit          xfer_data;
    bit          buf_v;
    logic [29:0] buf_tag;
    int          wait_left;
    int          force_waits = -1;
    bit          rand_en     = 0;
    int          reset_hold  = 3;

    // directed stimulus requests, consumed by drive()
    bit          dir_reset = 0;
    bit          dir_fetch_go = 0;
    logic [31:0] dir_fetch_addr;
    bit          dir_data_go = 0;
    bit          dir_data_rd, dir_data_wr;
    logic [31:0] dir_data_addr, dir_data_wd;
    logic [3:0]  dir_data_be;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h, expected %h (t=%0t)", tag, got, exp, $time);
    endtask

    function automatic logic [31:0] mem_rd(input logic [29:0] a);
        if (mem.exists(a)) return mem[a];
        return {a[13:0], 2'b10, ~a[15:0]};
    endfunction

    function automatic logic [31:0] rand_addr();
        int sel;
        logic [31:0] a;
        sel = $urandom_range(0, 5);
        a = (sel < 4) ? 32'(sel * 4) : 32'hBFC00000 + 32'((sel - 4) * 4);
        return a | 32'($urandom_range(0, 3));
    endfunction

    function automatic int pick_waits();
        if (force_waits >= 0) return force_waits;
        return ($urandom_range(0, 3) == 0) ? $urandom_range(1, 3) : 0;
    endfunction

    task automatic observe();
        @(posedge clk);
        #1;
        check("read", {31'd0, read}, {31'd0, e_read});
        check("write", {31'd0, write}, {31'd0, e_write});
        check("instr_valid", {31'd0, instr_valid}, {31'd0, e_ivalid});
        check("data_valid", {31'd0, data_valid}, {31'd0, e_dvalid});
        check("instr_readdata", instr_readdata, e_ird);
        check("data_readdata", data_readdata, e_drd);
        if (e_read || e_write || e_regs_check) begin
            check("address", address, e_addr);
            check("byteenable", {28'd0, byteenable}, {28'd0, e_be});
        end
        if (e_write || e_regs_check) check("writedata", writedata, e_wd);
    endtask

    task automatic drive();
        bit xfer;
        xfer = e_read | e_write;
        if (reset_hold > 0) begin
            reset = 1'b1;
            reset_hold--;
        end else if (dir_reset) begin
            reset = 1'b1;
            dir_reset = 0;
        end else begin
            reset = rand_en && ($urandom_range(0, 299) == 0);
        end

        if (instr_valid) instr_read = 1'b0;
        if (!instr_read) begin
            if (dir_fetch_go) begin
                instr_read = 1'b1;
                instr_address = dir_fetch_addr;
                dir_fetch_go = 0;
            end else if (rand_en && $urandom_range(0, 1) == 1) begin
                instr_read = 1'b1;
                instr_address = rand_addr();
            end
        end

        if (data_valid) begin
            data_read  = 1'b0;
            data_write = 1'b0;
        end
        if (!data_read && !data_write) begin
            if (dir_data_go) begin
                data_read = dir_data_rd;
                data_write = dir_data_wr;
                data_address = dir_data_addr;
                data_writedata = dir_data_wd;
                data_byteenable = dir_data_be;
                dir_data_go = 0;
            end else if (rand_en && $urandom_range(0, 1) == 1) begin
                case ($urandom_range(0, 3))
                    1: begin data_read = 1'b0; data_write = 1'b1; end
                    2: begin data_read = 1'b1; data_write = 1'b1; end
                    default: begin data_read = 1'b1; data_write = 1'b0; end
                endcase
                data_address = rand_addr();
                data_writedata = $urandom;
                data_byteenable = 4'($urandom_range(0, 15));
            end
        end

        if (xfer) begin
            if (wait_left > 0) begin
                waitrequest = 1'b1;
                wait_left--;
            end else begin
                waitrequest = 1'b0;
            end
            readdata = e_read ? mem_rd(e_addr[31:2]) : $urandom;
        end else begin
            waitrequest = 1'($urandom_range(0, 1));
            readdata = $urandom;
        end
        #1;
        check("memory_hazard", {31'd0, memory_hazard}, {31'd0, instr_read & ~e_ivalid});
    endtask

    task automatic predict();
        bit cv_i, cv_d, ipend, dpend, hit;
        logic [31:0] w;
        cv_i = e_ivalid;
        cv_d = e_dvalid;
        e_ivalid = 1'b0;
        e_dvalid = 1'b0;
        e_regs_check = 1'b0;
        if (reset) begin
            e_read = 0; e_write = 0; e_addr = 0; e_be = 0; e_wd = 0;
            e_ird = 0; e_drd = 0; e_regs_check = 1'b1;
            last_data = 0; buf_v = 0;
            return;
        end
        if (e_read || e_write) begin
            if (!waitrequest) begin
                if (e_write) begin
                    w = mem_rd(e_addr[31:2]);
                    for (int b = 0; b < 4; b++)
                        if (e_be[b]) w[8*b +: 8] = e_wd[8*b +: 8];
                    mem[e_addr[31:2]] = w;
                    if (buf_v && buf_tag == e_addr[31:2]) buf_v = 0;
                end
                if (xfer_data) begin
                    e_drd = readdata;
                    e_dvalid = 1'b1;
                end else begin
                    e_ird = readdata;
                    e_ivalid = 1'b1;
                    buf_v = 1;
                    buf_tag = e_addr[31:2];
                end
                e_read = 1'b0;
                e_write = 1'b0;
            end
        end else begin
            ipend = instr_read && !cv_i;
            dpend = (data_read || data_write) && !cv_d;
`ifdef MEM_ARBITER_FETCH_BUFFER_EN
            hit = buf_v && buf_tag == instr_address[31:2];
`else
            hit = 0;
`endif
            if (dpend && !(ipend && last_data)) begin
                e_write = data_write;
                e_read = !data_write;
                e_addr = {data_address[31:2], 2'b00};
                e_be = data_byteenable;
                e_wd = data_writedata;
                xfer_data = 1;
                last_data = 1;
                wait_left = pick_waits();
            end else if (ipend) begin
                last_data = 0;
                if (hit) begin
                    e_ivalid = 1'b1;
                    e_ird = mem_rd(instr_address[31:2]);
                end else begin
                    e_read = 1'b1;
                    e_addr = {instr_address[31:2], 2'b00};
                    e_be = 4'b1111;
                    xfer_data = 0;
                    wait_left = pick_waits();
                end
            end
        end
    endtask

    task automatic run_cycles(input int n);
        for (int i = 0; i < n; i++) begin
            observe();
            drive();
            predict();
        end
    endtask

    task automatic req_fetch(input logic [31:0] a);
        dir_fetch_go = 1;
        dir_fetch_addr = a;
    endtask

    task automatic req_data(input bit rd, input bit wr, input logic [31:0] a,
                            input logic [31:0] wd, input logic [3:0] be);
        dir_data_go = 1;
        dir_data_rd = rd;
        dir_data_wr = wr;
        dir_data_addr = a;
        dir_data_wd = wd;
        dir_data_be = be;
    endtask

    initial begin
        reset = 1'b1;
        instr_read = 0; instr_address = 0;
        data_read = 0; data_write = 0; data_address = 0;
        data_writedata = 0; data_byteenable = 0;
        waitrequest = 0; readdata = 0;
        e_ivalid = 0; e_dvalid = 0; e_read = 0; e_write = 0;
        wait_left = 0; xfer_data = 0; buf_tag = 0;
        mem[30'h2FF00000] = 32'h24020005;
        predict();
        run_cycles(4);

        // boot fetch
        req_fetch(32'hBFC00000);
        run_cycles(6);

        // store with a concurrent fetch: store first, fetch follows
        req_data(1'b0, 1'b1, 32'h00001003, 32'hA5A5_1234, 4'b1000);
        req_fetch(32'h00000008);
        run_cycles(12);

        // load stalled for three cycles
        force_waits = 3;
        req_data(1'b1, 1'b0, 32'h00000010, 32'h0, 4'b1111);
        run_cycles(9);

        // reset during a stalled load
        force_waits = 10;
        req_data(1'b1, 1'b0, 32'h00000020, 32'h0, 4'b1111);
        run_cycles(3);
        force_waits = -1;
        dir_reset = 1;
        run_cycles(10);

        // repeated fetch, store to the same word, fetch again
        req_fetch(32'hBFC00004);
        run_cycles(6);
        req_fetch(32'hBFC00004);
        run_cycles(5);
        req_data(1'b0, 1'b1, 32'hBFC00004, 32'h0BAD_F00D, 4'b1111);
        run_cycles(6);
        req_fetch(32'hBFC00004);
        run_cycles(6);

        rand_en = 1;
        run_cycles(4000);
        rand_en = 0;
        run_cycles(20);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

`default_nettype wire
